// File: rtl/sevseg_pkg.sv
// Shared constants for the multi-digit seven-segment controller: register map,
// CTRL bit positions and the hex-to-segment table (a = bit0 .. g = bit6, 1 = lit).
package sevseg_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_DECODE = 4'd9;
  localparam logic [3:0] ADDR_BLINK  = 4'd10;
  localparam logic [3:0] ADDR_BRIGHT = 4'd11;

  localparam int unsigned CTRL_ENABLE_BIT     = 0;
  localparam int unsigned CTRL_BLINK_SYNC_BIT = 1;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module sevseg_hex_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/sevseg_multi_ctrl.sv
// Avalon-MM multi-digit seven-segment controller: digit registers, per-digit
// decode/blink, global enable and PWM brightness driving active-low HEX outputs.
module sevseg_multi_ctrl
  import sevseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter int unsigned BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_DIGITS*8-1:0] hex_n
);

  localparam int unsigned PRE_W = $clog2(BLINK_DIV);
  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(BLINK_DIV - 1);
  localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = '1;

  logic [NUM_DIGITS-1:0][7:0]  digit_q, digit_d;
  logic                        enable_q, enable_d;
  logic [NUM_DIGITS-1:0]       decode_q, decode_d;
  logic [NUM_DIGITS-1:0]       blink_q, blink_d;
  logic [BRIGHT_W-1:0]         bright_q, bright_d;
  logic [PRE_W-1:0]            pre_q, pre_d;
  logic                        phase_q, phase_d;
  logic [BRIGHT_W-1:0]         pwm_q, pwm_d;
  logic [NUM_DIGITS*8-1:0]     hex_n_q, hex_n_d;

  logic [6:0]                  dec_seg_c [NUM_DIGITS];
  logic [NUM_DIGITS-1:0][7:0]  seg_sel_c;
  logic [NUM_DIGITS-1:0]       lit_c;
  logic                        wr_c, sync_c, pwm_on_c;
  logic                        unused_wdata_c;

  assign wr_c           = chipselect & ~write_n;
  assign sync_c         = wr_c && (address == ADDR_CTRL) && writedata[CTRL_BLINK_SYNC_BIT];
  assign pwm_on_c       = (bright_q == BRIGHT_MAX) || (pwm_q < bright_q);
  assign unused_wdata_c = ^writedata;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    sevseg_hex_decode u_dec (
      .nibble (digit_q[g][3:0]),
      .seg_c  (dec_seg_c[g])
    );
  end

  // Per-digit segment source and lit gating; dp rides along in both modes.
  always_comb begin
    seg_sel_c = '0;
    lit_c     = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      seg_sel_c[d] = decode_q[d] ? {digit_q[d][7], dec_seg_c[d]} : digit_q[d];
      lit_c[d]     = enable_q & pwm_on_c & ~(blink_q[d] & phase_q);
    end
  end

  always_comb begin
    digit_d  = digit_q;
    enable_d = enable_q;
    decode_d = decode_q;
    blink_d  = blink_q;
    bright_d = bright_q;
    pre_d    = pre_q + PRE_W'(1);
    phase_d  = phase_q;
    pwm_d    = pwm_q + BRIGHT_W'(1);
    hex_n_d  = '1;

    if (wr_c) begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        if (address == 4'(d)) digit_d[d] = writedata[7:0];
      end
      case (address)
        ADDR_CTRL:   enable_d = writedata[CTRL_ENABLE_BIT];
        ADDR_DECODE: decode_d = writedata[NUM_DIGITS-1:0];
        ADDR_BLINK:  blink_d  = writedata[NUM_DIGITS-1:0];
        ADDR_BRIGHT: bright_d = writedata[BRIGHT_W-1:0];
        default: ;
      endcase
    end

    // Resync beats the natural terminal-count toggle.
    if (sync_c) begin
      pre_d   = '0;
      phase_d = 1'b0;
    end else if (pre_q == PRE_LAST) begin
      pre_d   = '0;
      phase_d = ~phase_q;
    end

    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      hex_n_d[8*d +: 8] = ~(seg_sel_c[d] & {8{lit_c[d]}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q  <= '0;
      enable_q <= 1'b0;
      decode_q <= '1;
      blink_q  <= '0;
      bright_q <= '1;
      pre_q    <= '0;
      phase_q  <= 1'b0;
      pwm_q    <= '0;
      hex_n_q  <= '1;
    end else begin
      digit_q  <= digit_d;
      enable_q <= enable_d;
      decode_q <= decode_d;
      blink_q  <= blink_d;
      bright_q <= bright_d;
      pre_q    <= pre_d;
      phase_q  <= phase_d;
      pwm_q    <= pwm_d;
      hex_n_q  <= hex_n_d;
    end
  end

  assign hex_n = hex_n_q;

  always_comb begin
    readdata = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (address == 4'(d)) readdata = {24'h0, digit_q[d]};
    end
    case (address)
      ADDR_CTRL:   readdata = 32'(enable_q);
      ADDR_DECODE: readdata = 32'(decode_q);
      ADDR_BLINK:  readdata = 32'(blink_q);
      ADDR_BRIGHT: readdata = 32'(bright_q);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sevseg_multi_ctrl.sv
// Bench for sevseg_multi_ctrl (4 digits, blink half-period 4, 4-bit brightness):
// hand vectors, blink/PWM/reset sequences and random traffic against a cycle model.
module tb_sevseg_multi_ctrl;

  localparam int ND = 4;
  localparam int BD = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] hex_n;

  int total;
  int bad;

  sevseg_multi_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .BRIGHT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hex_n      (hex_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents plus edge counts since reset / since resync.
  bit [6:0]  seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit [7:0]  m_dig [ND];
  bit        m_en;
  bit [3:0]  m_dec, m_blink, m_bright;
  int        m_since, m_cyc;
  logic [31:0] m_hex;

  function automatic logic [31:0] model_hex();
    logic [31:0] r;
    bit phase;
    int pwm;
    bit on;
    bit [7:0] pat;
    bit lit;
    phase = ((m_since / BD) % 2) == 1;
    pwm   = m_cyc % 16;
    on    = (m_bright == 4'd15) || (pwm < int'(m_bright));
    for (int d = 0; d < ND; d++) begin
      pat = m_dec[d] ? {m_dig[d][7], seg_tbl[m_dig[d][3:0]]} : m_dig[d];
      lit = m_en && on && !(m_blink[d] && phase);
      r[8*d +: 8] = lit ? ~pat : 8'hFF;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    if (a < 4'(ND)) return {24'h0, m_dig[a[1:0]]};
    case (a)
      4'd8:    return {31'h0, m_en};
      4'd9:    return {28'h0, m_dec};
      4'd10:   return {28'h0, m_blink};
      4'd11:   return {28'h0, m_bright};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit sync;
    @(posedge clk);
    if (reset) begin
      for (int d = 0; d < ND; d++) m_dig[d] = 8'h00;
      m_en = 0; m_dec = 4'hF; m_blink = 4'h0; m_bright = 4'hF;
      m_since = 0; m_cyc = 0;
      m_hex = 32'hFFFF_FFFF;
    end else begin
      m_hex = model_hex();
      sync = 0;
      if (chipselect && !write_n) begin
        if (address < 4'(ND)) m_dig[address[1:0]] = writedata[7:0];
        case (address)
          4'd8:  begin m_en = writedata[0]; sync = writedata[1]; end
          4'd9:  m_dec    = writedata[3:0];
          4'd10: m_blink  = writedata[3:0];
          4'd11: m_bright = writedata[3:0];
          default: ;
        endcase
      end
      m_since = sync ? 0 : m_since + 1;
      m_cyc++;
    end
    #1;
    check("hex_n_model", hex_n, m_hex);
    check("readdata_model", readdata, model_read(address));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] data);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = data;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    address = a;
    tick();
    check("read_hand", readdata, exp);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [7:0]  exp_hex0;
    logic [3:0]  rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [13];
  int   lit_cnt;

  initial begin
    total = 0; bad = 0;
    vecs[0]  = '{4'd0,  32'h05,       8'h92, 4'd0,  32'h05};
    vecs[1]  = '{4'd0,  32'h0A,       8'h88, 4'd0,  32'h0A};
    vecs[2]  = '{4'd0,  32'h8B,       8'h03, 4'd0,  32'h8B};
    vecs[3]  = '{4'd0,  32'h0D,       8'hA1, 4'd0,  32'h0D};
    vecs[4]  = '{4'd0,  32'h0F,       8'h8E, 4'd0,  32'h0F};
    vecs[5]  = '{4'd9,  32'hFFFFFFFE, 8'hF0, 4'd9,  32'h0E};
    vecs[6]  = '{4'd0,  32'h49,       8'hB6, 4'd0,  32'h49};
    vecs[7]  = '{4'd0,  32'hFF,       8'h00, 4'd0,  32'hFF};
    vecs[8]  = '{4'd9,  32'h0F,       8'h0E, 4'd9,  32'h0F};
    vecs[9]  = '{4'd5,  32'h3C,       8'h0E, 4'd5,  32'h00};
    vecs[10] = '{4'd12, 32'h01,       8'h0E, 4'd12, 32'h00};
    vecs[11] = '{4'd8,  32'h00,       8'hFF, 4'd8,  32'h00};
    vecs[12] = '{4'd8,  32'h03,       8'h0E, 4'd8,  32'h01};

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 4'd0; writedata = '0;
    tick(); tick();
    check("reset_hex", hex_n, 32'hFFFF_FFFF);
    reset = 1'b0;
    rd(4'd0, 32'h0); rd(4'd8, 32'h0); rd(4'd9, 32'hF); rd(4'd10, 32'h0); rd(4'd11, 32'hF);

    // Enable then digit0=5: visible on the edge after the digit write.
    wr(4'd8, 32'h1);
    wr(4'd0, 32'h05);
    tick();
    check("first_display", hex_n, 32'hC0C0_C092);

    for (int i = 0; i < 13; i++) begin
      wr(vecs[i].addr, vecs[i].data);
      address = vecs[i].rd_addr;
      tick();
      check($sformatf("vec%0d_hex0", i), {24'h0, hex_n[7:0]}, {24'h0, vecs[i].exp_hex0});
      check($sformatf("vec%0d_read", i), readdata, vecs[i].exp_rd);
    end

    // Blink on digit0, resynced: lit 4 cycles then dark 4 cycles.
    wr(4'd0, 32'h05);
    wr(4'd10, 32'h1);
    wr(4'd8, 32'h3);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("blink_k%0d", k), {24'h0, hex_n[7:0]}, (k <= 4) ? 32'h92 : 32'hFF);
      check($sformatf("blink_d1_k%0d", k), {24'h0, hex_n[15:8]}, 32'hC0);
    end
    wr(4'd10, 32'h0);

    // PWM duty over a full 16-cycle period.
    wr(4'd11, 32'h4);
    lit_cnt = 0;
    for (int k = 0; k < 16; k++) begin tick(); if (hex_n[7:0] != 8'hFF) lit_cnt++; end
    check("pwm_bright4", lit_cnt, 4);
    wr(4'd11, 32'h0);
    lit_cnt = 0;
    for (int k = 0; k < 16; k++) begin tick(); if (hex_n[7:0] != 8'hFF) lit_cnt++; end
    check("pwm_bright0", lit_cnt, 0);
    wr(4'd11, 32'hF);
    lit_cnt = 0;
    for (int k = 0; k < 16; k++) begin tick(); if (hex_n[7:0] != 8'hFF) lit_cnt++; end
    check("pwm_bright15", lit_cnt, 16);

    for (int k = 0; k < 400; k++) begin
      reset      = ($urandom_range(0, 99) == 0);
      chipselect = ($urandom_range(0, 2) != 0);
      write_n    = ($urandom_range(0, 1) != 0);
      address    = 4'($urandom_range(0, 15));
      writedata  = $urandom;
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;

    // Reset mid-blink while the display is active.
    wr(4'd8, 32'h1);
    wr(4'd11, 32'hF);
    wr(4'd10, 32'hF);
    wr(4'd0, 32'h05);
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    check("midrun_reset_hex", hex_n, 32'hFFFF_FFFF);
    reset = 1'b0;
    rd(4'd0, 32'h0); rd(4'd8, 32'h0); rd(4'd9, 32'hF); rd(4'd10, 32'h0); rd(4'd11, 32'hF);
    check("post_reset_hex", hex_n, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sevseg_multi_ctrl.md
Name: sevseg_multi_ctrl

Overview:
- Parametrised successor to the single 8-bit seven-segment PIO.
- Avalon-MM slave holding up to 8 digit registers, plus per-digit hex-decode/raw selection, per-digit blink, global enable and PWM brightness.
- Drives the DE2-115 HEX displays directly: active-low segments, registered outputs.
- Sits on the Qsys system bus next to the other PIO peripherals.

Parameters:
- NUM_DIGITS, 8, number of digits driven (1..8).
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2); 0.5 s at 50 MHz.
- BRIGHT_W, 4, width of brightness register and PWM counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  4  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address.
- hex_n  out  NUM_DIGITS*8  per digit d: bits [8d+6:8d] = segments g..a, bit 8d+7 = dp; active low.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); all state changes on the rising edge of clk.
- A write occurs on an edge where chipselect=1, write_n=0 and address is valid.
- Register map (all unused bits read 0):
  - 0..NUM_DIGITS-1 DIGITn[7:0]. Decode mode: [3:0] hex nibble, [7] dp. Raw mode: [6:0] segments a..g, [7] dp. Logic 1 = lit.
  - 8 CTRL: [0] enable. [1] blink_sync, write-1 pulse, reads 0.
  - 9 DECODE[NUM_DIGITS-1:0]: 1 = hex decode for that digit.
  - 10 BLINK[NUM_DIGITS-1:0]: 1 = digit blinks.
  - 11 BRIGHT[BRIGHT_W-1:0].
  - Other addresses, and digit addresses >= NUM_DIGITS: writes ignored, reads 0.
- Reset values:
  - DIGITn = 0, CTRL.enable = 0, DECODE = all ones, BLINK = 0, BRIGHT = all ones.
  - Prescaler = 0, blink_phase = 0, pwm_cnt = 0.
  - hex_n = all ones (dark).
- Read path: readdata is combinational, zero wait states, valid in the same cycle as address.
- Write latency: register updates at write edge N; hex_n reflects the new value at edge N+1 (one output register stage).
- Decode table: standard hex 0-F; b, d lowercase; A, C, E, F uppercase. Segment order a=bit0 .. g=bit6.
- Blink prescaler counts 0..BLINK_DIV-1. At terminal count it wraps to 0 and toggles blink_phase.
  - A blink_sync write clears the prescaler and blink_phase on that edge; this takes priority over terminal count.
- PWM: pwm_cnt free-runs over 0..2^BRIGHT_W-1 with natural wrap.
  - pwm_on = (BRIGHT == all ones) or (pwm_cnt < BRIGHT).
  - BRIGHT = 0 gives dark.
- Per-digit lit mask = enable & pwm_on & ~(BLINK[d] & blink_phase).
- hex_n digit = ~(segments & {8{lit}}). dp is gated identically.
- Simultaneous events:
  - Write to DIGITn on the same edge as a blink or PWM transition: both take effect; the output at N+1 uses the new data and the new phase.
  - A single write touches one register only.
- Reset mid-operation: all state returns to reset values on that edge, and hex_n goes all ones on the same edge.

Decomposition:
- Package sevseg_pkg:
  - Register address constants (ADDR_CTRL=8, ADDR_DECODE=9, ADDR_BLINK=10, ADDR_BRIGHT=11).
  - CTRL bit indices.
  - The 16-entry hex-to-segment constant table.
- Sub-module sevseg_hex_decode: purely combinational, nibble in, 7 segments out. Instantiated NUM_DIGITS times.
- Prescaler, PWM, register file and output stage live in the top module.

Test Plan:
1. Reset, then write CTRL=1 and DIGIT0=0x05 (decode on).
   -> hex_n[7:0] = 0x92 two edges after the CTRL write. Other digits show "0" = 0xC0.
2. Write DECODE=0xFE and DIGIT0=0x49.
   -> hex_n[7:0] = 0xB6 (raw segments inverted). Read address 0 returns 0x00000049.
3. With BLINK_DIV=4: write BLINK=0x01.
   -> digit0 alternates 0xFF and its value every 4 cycles. A blink_sync write restarts the phase with the digit lit for the next 4 cycles.
4. BRIGHT=4 with BRIGHT_W=4.
   -> each digit is lit in exactly 4 of every 16 cycles. BRIGHT=0 -> always 0xFF. BRIGHT=15 -> always lit.
5. NUM_DIGITS=4: write address 5, then read addresses 5 and 12.
   -> both reads 0; hex_n unchanged.
6. Assert reset mid-blink while displaying.
   -> hex_n = all ones on that edge. All registers read back their reset values the next cycle.
